aline_capture_buffer: RTL and testbench

- Stage directly downstream of the ADC channel-A register; runs entirely in the ADC_data_out_clk domain.
- On each sweep-trigger rising edge, captures NSAMPLES consecutive ADC samples into one bank of a two-bank (ping-pong) buffer.
- Streams completed A-lines out over a valid/ready interface, so capture of line N+1 overlaps readout of line N.

---
 rtl/aline_capture_buffer_if.sv | 26 ++
 rtl/aline_capture_buffer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_aline_capture_buffer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aline_capture_buffer_if.sv
// Read-side stream of completed A-lines: valid/ready handshake plus line markers.
interface aline_capture_buffer_if #(
    parameter int unsigned DATA_W = 14
);
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic              rd_bank;
    logic              rd_ready;

    modport master (
        output rd_data,
        output rd_valid,
        output rd_last,
        output rd_bank,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        input  rd_last,
        input  rd_bank,
        output rd_ready
    );
endinterface

// File: rtl/aline_capture_buffer.sv
// A-line capture buffer: trigger-started capture of NSAMPLES ADC samples into a
// ping-pong RAM, with completed lines streamed out in capture order.
module aline_capture_buffer #(
    parameter int unsigned NSAMPLES = 1170,
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned DATA_W   = 14,
    parameter int unsigned SKIP     = 0
) (
    input  logic                  ADC_data_out_clk,
    input  logic                  global_reset_n,
    input  logic                  trigger_in,
    input  logic [DATA_W-1:0]     adc_data,
    input  logic                  acq_enable,
    aline_capture_buffer_if.master rd_if,
    output logic                  acq_busy,
    output logic                  overrun,
    output logic [15:0]           aline_count
);

    localparam int unsigned SKIP_W    = 8;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned MEM_AW    = ADDR_W + 1;
    localparam int unsigned MEM_DEPTH = 2 ** MEM_AW;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NSAMPLES - 1);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP == 0) ? 0 : SKIP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_CAPTURE
    } wr_state_t;

    // Trigger synchronizer and edge detect
    logic trig_sync1, trig_sync2, trig_prev;
    logic trig_pulse;

    // Sample register and write side
    logic [DATA_W-1:0] adc_q;
    wr_state_t         state, state_nxt;
    logic [SKIP_W-1:0] skip_cnt, skip_cnt_nxt;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
    logic              wr_en;
    logic              line_done;
    logic              overrun_nxt;
    logic              wr_bank;
    logic [1:0]        bank_full, bank_full_nxt;

    // Memory
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] ram_q;

    // Read side
    logic              rd_bank_q;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_done;
    logic              rd_en;
    logic              infl;
    logic              ram_last_q;
    logic              pop;
    logic              line_accept;
    logic [1:0]        occ;

    logic              head_valid, head_valid_nxt;
    logic              head_last, head_last_nxt;
    logic [DATA_W-1:0] head_data, head_data_nxt;
    logic              sk_valid, sk_valid_nxt;
    logic              sk_last, sk_last_nxt;
    logic [DATA_W-1:0] sk_data, sk_data_nxt;

    assign trig_pulse = trig_sync2 & ~trig_prev;

    // Bring the trigger into this clock domain and keep the previous level for edge detect
    always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            trig_sync1 <= 1'b0;
            trig_sync2 <= 1'b0;
            trig_prev  <= 1'b0;
        end else begin
            trig_sync1 <= trigger_in;
            trig_sync2 <= trig_sync1;
            trig_prev  <= trig_sync2;
        end
    end

    // Register the ADC sample once ahead of the RAM write
    always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            adc_q <= '0;
        end else begin
            adc_q <= adc_data;
        end
    end

    // Write FSM: next state, counters, write strobe and overrun decision
    always_comb begin
        state_nxt    = state;
        skip_cnt_nxt = skip_cnt;
        wr_addr_nxt  = wr_addr;
        wr_en        = 1'b0;
        line_done    = 1'b0;
        overrun_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig_pulse && acq_enable) begin
                    if (bank_full[wr_bank]) begin
                        overrun_nxt = 1'b1;
                    end else begin
                        skip_cnt_nxt = '0;
                        wr_addr_nxt  = '0;
                        state_nxt    = (SKIP == 0) ? ST_CAPTURE : ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                if (skip_cnt == SKIP_LAST) begin
                    state_nxt = ST_CAPTURE;
                end else begin
                    skip_cnt_nxt = skip_cnt + SKIP_W'(1);
                end
            end
            ST_CAPTURE: begin
                wr_en = 1'b1;
                if (wr_addr == ADDR_LAST) begin
                    line_done = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    wr_addr_nxt = wr_addr + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Write FSM state, bank pointer, line counter and status outputs
    always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state       <= ST_IDLE;
            skip_cnt    <= '0;
            wr_addr     <= '0;
            wr_bank     <= 1'b0;
            aline_count <= '0;
            acq_busy    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_cnt_nxt;
            wr_addr  <= wr_addr_nxt;
            acq_busy <= (state_nxt != ST_IDLE);
            overrun  <= overrun_nxt;
            if (line_done) begin
                wr_bank     <= ~wr_bank;
                aline_count <= aline_count + CNT_W'(1);
            end
        end
    end

    // Bank occupancy: writer fills, reader drains; both may update in one cycle
    always_comb begin
        bank_full_nxt = bank_full;
        if (line_done) begin
            bank_full_nxt[wr_bank] = 1'b1;
        end
        if (line_accept) begin
            bank_full_nxt[rd_bank_q] = 1'b0;
        end
    end

    always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            bank_full <= 2'b00;
        end else begin
            bank_full <= bank_full_nxt;
        end
    end

    // Ping-pong sample memory; reader and writer never share a bank
    always_ff @(posedge ADC_data_out_clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= adc_q;
        end
        if (rd_en) begin
            ram_q <= mem[{rd_bank_q, fetch_addr}];
        end
    end

    // Issue a read only when the skid storage can absorb it after this cycle's pop
    assign pop         = head_valid & rd_if.rd_ready;
    assign line_accept = pop & head_last;
    assign occ         = 2'(head_valid) + 2'(sk_valid) + 2'(infl);
    assign rd_en       = bank_full[rd_bank_q] && !fetch_done && (occ <= (2'd1 + 2'(pop)));

    // Read address generation and bank pointer
    always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            rd_bank_q  <= 1'b0;
            fetch_addr <= '0;
            fetch_done <= 1'b0;
            infl       <= 1'b0;
            ram_last_q <= 1'b0;
        end else begin
            infl       <= rd_en;
            ram_last_q <= rd_en && (fetch_addr == ADDR_LAST);
            if (line_accept) begin
                rd_bank_q  <= ~rd_bank_q;
                fetch_addr <= '0;
                fetch_done <= 1'b0;
            end else if (rd_en) begin
                if (fetch_addr == ADDR_LAST) begin
                    fetch_done <= 1'b1;
                end else begin
                    fetch_addr <= fetch_addr + ADDR_W'(1);
                end
            end
        end
    end

    // Two-entry skid: head drives the outputs, second slot catches the in-flight read
    always_comb begin
        head_valid_nxt = head_valid;
        head_last_nxt  = head_last;
        head_data_nxt  = head_data;
        sk_valid_nxt   = sk_valid;
        sk_last_nxt    = sk_last;
        sk_data_nxt    = sk_data;
        if (!head_valid || pop) begin
            if (sk_valid) begin
                head_valid_nxt = 1'b1;
                head_last_nxt  = sk_last;
                head_data_nxt  = sk_data;
                sk_valid_nxt   = infl;
                sk_last_nxt    = ram_last_q;
                sk_data_nxt    = ram_q;
            end else if (infl) begin
                head_valid_nxt = 1'b1;
                head_last_nxt  = ram_last_q;
                head_data_nxt  = ram_q;
            end else begin
                head_valid_nxt = 1'b0;
            end
        end else if (infl) begin
            sk_valid_nxt = 1'b1;
            sk_last_nxt  = ram_last_q;
            sk_data_nxt  = ram_q;
        end
    end

    always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            head_valid <= 1'b0;
            head_last  <= 1'b0;
            head_data  <= '0;
            sk_valid   <= 1'b0;
            sk_last    <= 1'b0;
            sk_data    <= '0;
        end else begin
            head_valid <= head_valid_nxt;
            head_last  <= head_last_nxt;
            head_data  <= head_data_nxt;
            sk_valid   <= sk_valid_nxt;
            sk_last    <= sk_last_nxt;
            sk_data    <= sk_data_nxt;
        end
    end

    assign rd_if.rd_data  = head_data;
    assign rd_if.rd_valid = head_valid;
    assign rd_if.rd_last  = head_last;
    assign rd_if.rd_bank  = rd_bank_q;

endmodule

// File: tb/tb_aline_capture_buffer.sv
// Bench for aline_capture_buffer: two instances (SKIP=0 and SKIP=3) share stimulus
// and are checked against a cycle-stamped line/bank model.
module tb_aline_capture_buffer;

    localparam int unsigned N    = 8;
    localparam int unsigned AW   = 3;
    localparam int unsigned DW   = 14;
    localparam int          MAXC = 8192;

    logic          clk;
    logic          rst_n;
    logic          trigger_in;
    logic          acq_enable;
    logic          rd_ready;
    logic [DW-1:0] adc_data;
    logic          busy0, busy1, ovr0, ovr1;
    logic [15:0]   cnt0, cnt1;

    aline_capture_buffer_if #(.DATA_W(DW)) if0 ();
    aline_capture_buffer_if #(.DATA_W(DW)) if1 ();

    assign if0.rd_ready = rd_ready;
    assign if1.rd_ready = rd_ready;

    aline_capture_buffer #(.NSAMPLES(N), .ADDR_W(AW), .DATA_W(DW), .SKIP(0)) dut0 (
        .ADC_data_out_clk (clk),
        .global_reset_n   (rst_n),
        .trigger_in       (trigger_in),
        .adc_data         (adc_data),
        .acq_enable       (acq_enable),
        .rd_if            (if0),
        .acq_busy         (busy0),
        .overrun          (ovr0),
        .aline_count      (cnt0)
    );

    aline_capture_buffer #(.NSAMPLES(N), .ADDR_W(AW), .DATA_W(DW), .SKIP(3)) dut1 (
        .ADC_data_out_clk (clk),
        .global_reset_n   (rst_n),
        .trigger_in       (trigger_in),
        .adc_data         (adc_data),
        .acq_enable       (acq_enable),
        .rd_if            (if1),
        .acq_busy         (busy1),
        .overrun          (ovr1),
        .aline_count      (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int cyc;
    bit use_ramp;

    int adc_hist [MAXC];
    bit trig_hist[MAXC];

    // Model state per instance
    int skip_of   [2];
    int busy_from [2];
    int busy_until[2];
    int done_at   [2];
    int full_cnt  [2];
    int exp_cnt   [2];
    int ovr_at    [2];
    int beat_idx  [2];
    int lq_head   [2];
    int lq_cnt    [2];
    int line_start[2][4];
    bit exp_bank  [2];
    bit empty_pend[2];
    bit prev_stall[2];
    int prev_data [2];
    bit prev_last [2];

    // Observed outputs
    bit o_valid[2], o_last[2], o_bank[2], o_busy[2], o_ovr[2];
    int o_data[2], o_cnt[2];

    task automatic check_val(input string tag, input int d, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s dut%0d cyc %0d got %0d exp %0d", tag, d, cyc, got, exp);
        end
    endtask

    task automatic sample();
        o_valid[0] = if0.rd_valid; o_last[0] = if0.rd_last; o_bank[0] = if0.rd_bank;
        o_data[0]  = int'(if0.rd_data); o_busy[0] = busy0; o_ovr[0] = ovr0; o_cnt[0] = int'(cnt0);
        o_valid[1] = if1.rd_valid; o_last[1] = if1.rd_last; o_bank[1] = if1.rd_bank;
        o_data[1]  = int'(if1.rd_data); o_busy[1] = busy1; o_ovr[1] = ovr1; o_cnt[1] = int'(cnt1);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            busy_from[d]  = 1;
            busy_until[d] = 0;
            done_at[d]    = -1;
            full_cnt[d]   = 0;
            exp_cnt[d]    = 0;
            ovr_at[d]     = -1;
            beat_idx[d]   = 0;
            lq_head[d]    = 0;
            lq_cnt[d]     = 0;
            exp_bank[d]   = 1'b0;
            empty_pend[d] = 1'b0;
            prev_stall[d] = 1'b0;
        end
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model
    task automatic cycle(input bit trig, input bit ready, input bit en);
        bit pulse;
        int s;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget dut0 cyc %0d got %0d exp %0d", cyc, cyc, MAXC - 1);
            $fatal(1, "cycle budget exhausted");
        end
        sample();
        for (int d = 0; d < 2; d++) begin
            if (done_at[d] == cyc) begin
                full_cnt[d]++;
                exp_cnt[d]++;
                done_at[d] = -1;
            end
            if (empty_pend[d]) begin
                full_cnt[d]--;
                exp_bank[d]   = ~exp_bank[d];
                empty_pend[d] = 1'b0;
            end
            check_val("acq_busy", d, int'(o_busy[d]), int'(cyc >= busy_from[d] && cyc <= busy_until[d]));
            check_val("overrun", d, int'(o_ovr[d]), int'(cyc == ovr_at[d]));
            check_val("aline_count", d, o_cnt[d], exp_cnt[d] % 65536);
            check_val("rd_bank", d, int'(o_bank[d]), int'(exp_bank[d]));
            if (prev_stall[d]) begin
                check_val("stall_valid", d, int'(o_valid[d]), 1);
                check_val("stall_data", d, o_data[d], prev_data[d]);
                check_val("stall_last", d, int'(o_last[d]), int'(prev_last[d]));
            end
        end

        trigger_in = trig;
        rd_ready   = ready;
        acq_enable = en;
        adc_data   = use_ramp ? DW'(cyc) : DW'($urandom);
        adc_hist[cyc]  = int'(adc_data);
        trig_hist[cyc] = rst_n && trig;
        pulse = (cyc >= 3) && trig_hist[cyc-2] && !trig_hist[cyc-3];

        for (int d = 0; d < 2; d++) begin
            if (rst_n && pulse && en && cyc > busy_until[d]) begin
                if (full_cnt[d] < 2) begin
                    busy_from[d]  = cyc + 1;
                    busy_until[d] = cyc + skip_of[d] + N;
                    done_at[d]    = cyc + skip_of[d] + N + 1;
                    line_start[d][(lq_head[d] + lq_cnt[d]) % 4] = cyc + skip_of[d];
                    lq_cnt[d]++;
                end else begin
                    ovr_at[d] = cyc + 1;
                end
            end
            if (rst_n && o_valid[d] && ready) begin
                if (lq_cnt[d] == 0) begin
                    check_val("spurious_beat", d, int'(o_valid[d]), 0);
                end else begin
                    s = line_start[d][lq_head[d]];
                    check_val("line_complete", d, int'(cyc >= s + int'(N) + 1), 1);
                    check_val("rd_data", d, o_data[d], adc_hist[s + beat_idx[d]]);
                    check_val("rd_last", d, int'(o_last[d]), int'(beat_idx[d] == int'(N) - 1));
                    beat_idx[d]++;
                    if (beat_idx[d] == int'(N)) begin
                        beat_idx[d]   = 0;
                        lq_head[d]    = (lq_head[d] + 1) % 4;
                        lq_cnt[d]--;
                        empty_pend[d] = 1'b1;
                    end
                end
            end
            prev_stall[d] = o_valid[d] && !ready;
            prev_data[d]  = o_data[d];
            prev_last[d]  = o_last[d];
        end
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        trigger_in = 1'b0;
        #1;
        sample();
        for (int d = 0; d < 2; d++) begin
            check_val("rst_rd_valid", d, int'(o_valid[d]), 0);
            check_val("rst_rd_data", d, o_data[d], 0);
            check_val("rst_rd_last", d, int'(o_last[d]), 0);
            check_val("rst_rd_bank", d, int'(o_bank[d]), 0);
            check_val("rst_acq_busy", d, int'(o_busy[d]), 0);
            check_val("rst_overrun", d, int'(o_ovr[d]), 0);
            check_val("rst_aline_count", d, o_cnt[d], 0);
        end
        model_reset();
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((lq_cnt[0] != 0 || lq_cnt[1] != 0) && k < budget) begin
            cycle(1'b0, 1'b1, 1'b1);
            k++;
        end
        repeat (3) cycle(1'b0, 1'b1, 1'b1);
        check_val("drain", 0, lq_cnt[0], 0);
        check_val("drain", 1, lq_cnt[1], 0);
    endtask

    initial begin
        bit tr;
        int pct;
        bit pat[5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        use_ramp = 1'b1;
        skip_of[0] = 0;
        skip_of[1] = 3;
        rst_n      = 1'b1;
        trigger_in = 1'b0;
        acq_enable = 1'b0;
        rd_ready   = 1'b0;
        adc_data   = '0;
        for (int i = 0; i < MAXC; i++) begin
            adc_hist[i]  = 0;
            trig_hist[i] = 1'b0;
        end
        model_reset();

        #2;
        reset_now();
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;

        // Single line, ramp data, consumer always ready
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        repeat (40) cycle(1'b0, 1'b1, 1'b1);

        // Three triggers 10 cycles apart with the consumer stalled, then drain
        for (int k = 0; k < 3; k++) begin
            repeat (2) cycle(1'b1, 1'b0, 1'b1);
            repeat (8) cycle(1'b0, 1'b0, 1'b1);
        end
        repeat (20) cycle(1'b0, 1'b0, 1'b1);
        drain(100);

        // Back-pressure pattern during a stream
        use_ramp = 1'b0;
        repeat (2) cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b0, pat[i % 5], 1'b1);
        drain(100);

        // Trigger with acquisition disarmed, then a second trigger during capture
        repeat (2) cycle(1'b1, 1'b1, 1'b0);
        repeat (6) cycle(1'b0, 1'b1, 1'b0);
        repeat (2) cycle(1'b1, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b1, 1'b1);
        repeat (2) cycle(1'b1, 1'b1, 1'b1);
        repeat (20) cycle(1'b0, 1'b1, 1'b1);
        drain(100);

        // Reset while the SKIP=0 instance writes address 4, then a fresh line
        repeat (2) cycle(1'b1, 1'b1, 1'b1);
        repeat (6) cycle(1'b0, 1'b1, 1'b1);
        reset_now();
        repeat (3) cycle(1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
        repeat (2) cycle(1'b1, 1'b1, 1'b1);
        repeat (30) cycle(1'b0, 1'b1, 1'b1);

        // Randomized triggers, enable and back-pressure
        tr  = 1'b0;
        pct = 100;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                case ((i / 250) % 4)
                    0:       pct = 100;
                    1:       pct = 60;
                    2:       pct = 25;
                    default: pct = 5;
                endcase
            end
            if ($urandom_range(0, 9) == 0) tr = ~tr;
            cycle(tr, int'($urandom_range(0, 99)) < pct, $urandom_range(0, 19) != 0);
        end
        drain(300);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
